// File: rtl/alu_issue_pkg.sv
// Shared op codes, FSM state type and op classification helpers for the ALU issue stage.
package alu_issue_pkg;

    // Class field value that selects register-form operands
    localparam logic [2:0] REG_CLASS = 3'b010;

    // Supported ALU op codes
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MULT = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00100;
    localparam logic [4:0] OP_REM  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b01001;
    localparam logic [4:0] OP_SLL  = 5'b01010;
    localparam logic [4:0] OP_SRL  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_SLT  = 5'b01101;
    localparam logic [4:0] OP_SEQ  = 5'b10000;
    localparam logic [4:0] OP_SNE  = 5'b10001;
    localparam logic [4:0] OP_SGE  = 5'b10010;
    localparam logic [4:0] OP_SLE  = 5'b10011;
    localparam logic [4:0] OP_MIN  = 5'b10101;
    localparam logic [4:0] OP_MAX  = 5'b10110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_REM, OP_AND, OP_NOT,
            OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
            OP_SEQ, OP_SNE, OP_SGE, OP_SLE, OP_MIN, OP_MAX: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Ops that keep the ALU occupied for several cycles after issue
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-side and ALU-side handshake bundle. master drives instructions and
// consumes decoded ops; slave is the issue stage itself.
interface alu_issue_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int WB_W   = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               instr;
    logic [DATA_W-1:0]         f_val;
    logic [DATA_W-1:0]         s_val;
    logic [DATA_W-1:0]         t_val;
    logic [WB_W+IMM_W-1:0]     imm;

    logic                      out_valid;
    logic                      out_ready;
    logic [4:0]                alu_op;
    logic signed [DATA_W-1:0]  alu_v1;
    logic signed [DATA_W-1:0]  alu_v2;
    logic                      wb_flag;
    logic [WB_W-1:0]           wb_code;
    logic                      illegal_op;
    logic                      busy;

    modport master (
        output in_valid, instr, f_val, s_val, t_val, imm, out_ready,
        input  in_ready, out_valid, alu_op, alu_v1, alu_v2, wb_flag, wb_code,
               illegal_op, busy
    );

    modport slave (
        input  in_valid, instr, f_val, s_val, t_val, imm, out_ready,
        output in_ready, out_valid, alu_op, alu_v1, alu_v2, wb_flag, wb_code,
               illegal_op, busy
    );
endinterface

// File: rtl/alu_operand_mux.sv
// Combinational decode of one instruction into op code, operands and
// write-back target, plus legality / multi-cycle classification.
module alu_operand_mux
    import alu_issue_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int IMM_W        = 16,
    parameter int WB_W         = 8,
    parameter int SIGN_EXT_IMM = 0
) (
    input  logic [2:0]               cls,
    input  logic [4:0]               op,
    input  logic [DATA_W-1:0]        f_val,
    input  logic [DATA_W-1:0]        s_val,
    input  logic [DATA_W-1:0]        t_val,
    input  logic [WB_W+IMM_W-1:0]    imm,
    output logic [4:0]               alu_op,
    output logic signed [DATA_W-1:0] v1,
    output logic signed [DATA_W-1:0] v2,
    output logic [WB_W-1:0]          wb_code,
    output logic                     legal,
    output logic                     muldiv
);

    logic [DATA_W-1:0] imm_ext;
    logic              is_reg;

    assign is_reg  = (cls == REG_CLASS);
    assign alu_op  = op;
    assign wb_code = imm[WB_W+IMM_W-1:IMM_W];
    assign legal   = is_legal_op(op);
    assign muldiv  = is_muldiv(op);

    // Widen the immediate value to operand width
    always_comb begin
        if (SIGN_EXT_IMM != 0)
            imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm[IMM_W-1:0]};
        else
            imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm[IMM_W-1:0]};
    end

    // Operand selection; NOT is unary so its second operand is forced to zero
    always_comb begin
        if (is_reg) begin
            v1 = f_val;
            v2 = (op == OP_NOT) ? '0 : s_val;
        end else if (op == OP_NOT) begin
            v1 = imm_ext;
            v2 = '0;
        end else begin
            v1 = t_val;
            v2 = imm_ext;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage between register read and the ALU: decodes one op
// per cycle into a held output register, stalls issue during multi-cycle
// MULT/DIV/REM, and pulses illegal_op for unsupported op codes.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int IMM_W        = 16,
    parameter int WB_W         = 8,
    parameter int SIGN_EXT_IMM = 0,
    parameter int MULDIV_LAT   = 4
) (
    input  logic      clk,
    input  logic      reset,
    alu_issue_if.slave bus
);

    localparam int CNT_W = $clog2(MULDIV_LAT + 1);

    if (IMM_W >= DATA_W) begin : g_bad_imm_w
        $error("alu_issue_stage: IMM_W must be smaller than DATA_W");
    end
    if (MULDIV_LAT < 1) begin : g_bad_lat
        $error("alu_issue_stage: MULDIV_LAT must be at least 1");
    end

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;

    logic [4:0]               dec_op;
    logic signed [DATA_W-1:0] dec_v1, dec_v2;
    logic [WB_W-1:0]          dec_wb;
    logic                     dec_legal, dec_muldiv;

    logic [4:0]               op_q;
    logic signed [DATA_W-1:0] v1_q, v2_q;
    logic [WB_W-1:0]          wb_code_q;
    logic                     wb_flag_q, illegal_q, muldiv_q;

    logic                     in_ready, out_valid, busy;
    logic                     accept, legal_acc, fire, enter_stall;
    logic                     unused_instr;

    assign unused_instr = ^bus.instr[23:0];

    alu_operand_mux #(
        .DATA_W       (DATA_W),
        .IMM_W        (IMM_W),
        .WB_W         (WB_W),
        .SIGN_EXT_IMM (SIGN_EXT_IMM)
    ) u_mux (
        .cls     (bus.instr[31:29]),
        .op      (bus.instr[28:24]),
        .f_val   (bus.f_val),
        .s_val   (bus.s_val),
        .t_val   (bus.t_val),
        .imm     (bus.imm),
        .alu_op  (dec_op),
        .v1      (dec_v1),
        .v2      (dec_v2),
        .wb_code (dec_wb),
        .legal   (dec_legal),
        .muldiv  (dec_muldiv)
    );

    assign accept      = bus.in_valid & in_ready;
    assign legal_acc   = accept & dec_legal;
    assign fire        = out_valid & bus.out_ready;
    assign enter_stall = (state == ST_HOLD) & fire & muldiv_q & (MULDIV_LAT > 1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (legal_acc) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (fire) begin
                    if (enter_stall)    state_nxt = ST_STALL;
                    else if (legal_acc) state_nxt = ST_HOLD;
                    else                state_nxt = ST_IDLE;
                end
            end
            ST_STALL: if (cnt <= CNT_W'(1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and status outputs; a held muldiv cannot be followed by a new
    // accept because the ALU will be occupied once it fires
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE:  in_ready = ~reset;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = ~reset & bus.out_ready & ~muldiv_q;
            end
            ST_STALL: busy = 1'b1;
            default:  ;
        endcase
    end

    // Occupancy counter for multi-cycle ops
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (enter_stall)
            cnt <= CNT_W'(MULDIV_LAT - 1);
        else if ((state == ST_STALL) && (cnt != '0))
            cnt <= cnt - CNT_W'(1);
    end

    // Output register: loads only on a legal accept, otherwise holds
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            wb_code_q <= '0;
            wb_flag_q <= 1'b0;
            muldiv_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept & ~dec_legal;
            if (legal_acc) begin
                op_q      <= dec_op;
                v1_q      <= dec_v1;
                v2_q      <= dec_v2;
                wb_code_q <= dec_wb;
                wb_flag_q <= 1'b1;
                muldiv_q  <= dec_muldiv;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = busy;
    assign bus.alu_op     = op_q;
    assign bus.alu_v1     = v1_q;
    assign bus.alu_v2     = v2_q;
    assign bus.wb_code    = wb_code_q;
    assign bus.wb_flag    = wb_flag_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, handshake, muldiv stall,
// illegal ops and reset. Inputs change and outputs are sampled on negedge.
module tb_alu_issue_stage;

    localparam logic [2:0] C_REG = 3'b010;
    localparam logic [2:0] C_IMM = 3'b000;
    localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00010, MULT = 5'b00011,
                           DIV = 5'b00100, AND = 5'b00110, NOT = 5'b00111,
                           OR  = 5'b01000, XOR = 5'b01001;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_issue_if #(.DATA_W(32), .IMM_W(16), .WB_W(8)) u_if ();
    alu_issue_if #(.DATA_W(32), .IMM_W(16), .WB_W(8)) u_if_sx ();

    alu_issue_stage #(.SIGN_EXT_IMM(0), .MULDIV_LAT(4)) u_dut (
        .clk(clk), .reset(reset), .bus(u_if)
    );
    alu_issue_stage #(.SIGN_EXT_IMM(1), .MULDIV_LAT(4)) u_dut_sx (
        .clk(clk), .reset(reset), .bus(u_if_sx)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] cls, input logic [4:0] op,
                         input logic [31:0] f, input logic [31:0] s,
                         input logic [31:0] t, input logic [23:0] im);
        u_if.in_valid = 1'b1;
        u_if.instr    = {cls, op, 24'h0};
        u_if.f_val    = f;
        u_if.s_val    = s;
        u_if.t_val    = t;
        u_if.imm      = im;
    endtask

    task automatic idle();
        u_if.in_valid = 1'b0;
        u_if.instr    = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        u_if.f_val = '0; u_if.s_val = '0; u_if.t_val = '0; u_if.imm = '0;
        u_if.out_ready = 1'b1;
        u_if_sx.in_valid = 1'b0; u_if_sx.instr = '0; u_if_sx.f_val = '0;
        u_if_sx.s_val = '0; u_if_sx.t_val = '0; u_if_sx.imm = '0;
        u_if_sx.out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(u_if.in_ready), 0);
        chk("rst_out_valid", 32'(u_if.out_valid), 0);
        chk("rst_op", 32'(u_if.alu_op), 0);
        chk("rst_busy", 32'(u_if.busy), 0);
        reset = 1'b0;
        #1 chk("idle_in_ready", 32'(u_if.in_ready), 1);

        // ADD register form, then ADDi zero/sign extended
        issue(C_REG, ADD, 5, 32'hFFFF_FFFD, 0, 24'hAB_0000);
        @(negedge clk);
        chk("add_vld", 32'(u_if.out_valid), 1);
        chk("add_op", 32'(u_if.alu_op), 32'(ADD));
        chk("add_v1", u_if.alu_v1, 5);
        chk("add_v2", u_if.alu_v2, 32'hFFFF_FFFD);
        chk("add_wb", 32'(u_if.wb_code), 32'hAB);
        chk("add_wbf", 32'(u_if.wb_flag), 1);
        issue(C_IMM, ADD, 0, 0, 7, 24'h12_FFFF);
        u_if_sx.in_valid = 1'b1; u_if_sx.instr = {C_IMM, ADD, 24'h0};
        u_if_sx.t_val = 7; u_if_sx.imm = 24'h12_FFFF;
        @(negedge clk);
        chk("addi_v1", u_if.alu_v1, 7);
        chk("addi_v2_zext", u_if.alu_v2, 32'h0000_FFFF);
        chk("addi_wb", 32'(u_if.wb_code), 32'h12);
        chk("addi_sx_v1", u_if_sx.alu_v1, 7);
        chk("addi_v2_sext", u_if_sx.alu_v2, 32'hFFFF_FFFF);
        idle();
        u_if_sx.in_valid = 1'b0;
        @(negedge clk);
        chk("addi_done_vld", 32'(u_if.out_valid), 0);

        // back-to-back ADD, SUB, XOR
        issue(C_REG, ADD, 1, 2, 0, 24'h01_0000);
        #1 chk("b2b_rdy0", 32'(u_if.in_ready), 1);
        @(negedge clk);
        chk("b2b_vld0", 32'(u_if.out_valid), 1);
        chk("b2b_op0", 32'(u_if.alu_op), 32'(ADD));
        issue(C_REG, SUB, 10, 4, 0, 24'h02_0000);
        #1 chk("b2b_rdy1", 32'(u_if.in_ready), 1);
        @(negedge clk);
        chk("b2b_vld1", 32'(u_if.out_valid), 1);
        chk("b2b_op1", 32'(u_if.alu_op), 32'(SUB));
        chk("b2b_v1_1", u_if.alu_v1, 10);
        issue(C_REG, XOR, 6, 3, 0, 24'h03_0000);
        #1 chk("b2b_rdy2", 32'(u_if.in_ready), 1);
        @(negedge clk);
        chk("b2b_vld2", 32'(u_if.out_valid), 1);
        chk("b2b_op2", 32'(u_if.alu_op), 32'(XOR));
        idle();
        @(negedge clk);

        // back-pressure: op held stable for 3 cycles, then released
        issue(C_REG, AND, 32'h55, 32'h0F, 0, 24'h21_0000);
        @(negedge clk);
        chk("bp_vld", 32'(u_if.out_valid), 1);
        u_if.out_ready = 1'b0;
        issue(C_REG, OR, 3, 4, 0, 24'h22_0000);
        #1 chk("bp_rdy", 32'(u_if.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_vld", 32'(u_if.out_valid), 1);
            chk("bp_hold_op", 32'(u_if.alu_op), 32'(AND));
            chk("bp_hold_v1", u_if.alu_v1, 32'h55);
            chk("bp_hold_wb", 32'(u_if.wb_code), 32'h21);
            chk("bp_hold_rdy", 32'(u_if.in_ready), 0);
        end
        u_if.out_ready = 1'b1;
        #1 chk("bp_rel_rdy", 32'(u_if.in_ready), 1);
        @(negedge clk);
        chk("bp_next_op", 32'(u_if.alu_op), 32'(OR));
        chk("bp_next_v1", u_if.alu_v1, 3);
        idle();
        @(negedge clk);

        // DIV fire: 3 busy cycles, next accept exactly 4 cycles after the fire
        issue(C_REG, DIV, 100, 7, 0, 24'h05_0000);
        @(negedge clk);
        chk("div_vld", 32'(u_if.out_valid), 1);
        chk("div_op", 32'(u_if.alu_op), 32'(DIV));
        issue(C_REG, ADD, 9, 1, 0, 24'h06_0000);
        #1 chk("div_rdy", 32'(u_if.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_busy", 32'(u_if.busy), 1);
            chk("stall_rdy", 32'(u_if.in_ready), 0);
            chk("stall_vld", 32'(u_if.out_valid), 0);
        end
        @(negedge clk);
        chk("stall_end_busy", 32'(u_if.busy), 0);
        chk("stall_end_rdy", 32'(u_if.in_ready), 1);
        @(negedge clk);
        chk("post_div_vld", 32'(u_if.out_valid), 1);
        chk("post_div_v1", u_if.alu_v1, 9);
        idle();
        @(negedge clk);

        // illegal op from IDLE, NOTi, illegal during a HOLD fire, register NOT
        issue(C_REG, 5'b01110, 1, 2, 3, 24'h07_0000);
        @(negedge clk);
        chk("ill_pulse", 32'(u_if.illegal_op), 1);
        chk("ill_vld", 32'(u_if.out_valid), 0);
        idle();
        @(negedge clk);
        chk("ill_clear", 32'(u_if.illegal_op), 0);
        issue(C_IMM, NOT, 0, 0, 32'hDEAD, 24'h33_00F0);
        @(negedge clk);
        chk("noti_v1", u_if.alu_v1, 32'h0000_00F0);
        chk("noti_v2", u_if.alu_v2, 0);
        chk("noti_wb", 32'(u_if.wb_code), 32'h33);
        issue(C_REG, 5'b11111, 1, 2, 3, 24'h08_0000);
        @(negedge clk);
        chk("hold_ill_vld", 32'(u_if.out_valid), 0);
        chk("hold_ill_pulse", 32'(u_if.illegal_op), 1);
        issue(C_REG, NOT, 32'h1234, 32'h99, 0, 24'h09_0000);
        @(negedge clk);
        chk("not_v1", u_if.alu_v1, 32'h1234);
        chk("not_v2", u_if.alu_v2, 0);
        idle();
        @(negedge clk);

        // reset mid-STALL
        issue(C_REG, MULT, 2, 3, 0, 24'h0A_0000);
        @(negedge clk);
        chk("mul_vld", 32'(u_if.out_valid), 1);
        idle();
        @(negedge clk);
        chk("mul_busy", 32'(u_if.busy), 1);
        reset = 1'b1;
        #1 chk("rst_stall_rdy", 32'(u_if.in_ready), 0);
        @(negedge clk);
        chk("rs_busy", 32'(u_if.busy), 0);
        chk("rs_vld", 32'(u_if.out_valid), 0);
        chk("rs_op", 32'(u_if.alu_op), 0);
        chk("rs_v1", u_if.alu_v1, 0);
        chk("rs_v2", u_if.alu_v2, 0);
        chk("rs_wb", 32'(u_if.wb_code), 0);
        chk("rs_wbf", 32'(u_if.wb_flag), 0);
        reset = 1'b0;
        #1 chk("rs_rdy", 32'(u_if.in_ready), 1);

        // reset during HOLD
        issue(C_REG, ADD, 5, 6, 0, 24'h44_0000);
        @(negedge clk);
        chk("rh_vld_pre", 32'(u_if.out_valid), 1);
        u_if.out_ready = 1'b0;
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rh_vld", 32'(u_if.out_valid), 0);
        chk("rh_op", 32'(u_if.alu_op), 0);
        chk("rh_v1", u_if.alu_v1, 0);
        chk("rh_wb", 32'(u_if.wb_code), 0);
        reset = 1'b0;
        u_if.out_ready = 1'b1;
        #1 chk("rh_rdy", 32'(u_if.in_ready), 1);
        @(negedge clk);
        chk("rh_idle_vld", 32'(u_if.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
